bundler_seq_ctrl: RTL and testbench
===================================

# bundler_seq_ctrl

Sequencer that drives the per-bit majority bundler (`bundler_bit`) across a whole hypervector. It latches NUM_HVS hypervectors of DIM bits on `start` and walks the dimension index from 0 to DIM-1. For each index it issues one `en` transaction carrying that bit column plus LFSR tie-break bits, waits for the bundler's `done`, and stores `out_bit` into the bundled output hypervector. It sits between the encoder stage that produces channel/time hypervectors and the associative-memory stage.

## Interface
- `NUM_HVS`, 6: hypervectors bundled; even or odd.
- `DIM`, 64: hypervector width in bits; ≥1.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `TIMEOUT`, 16: max WAIT cycles; used only with the timeout feature.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a bundle; sampled only in IDLE.
- `hv_in`  in  NUM_HVS*DIM  hypervector k at [k*DIM +: DIM]; sampled on the accepted `start` edge.
- `busy`  out  1  high from the cycle after an accepted start through the FIN cycle.
- `done`  out  1  one-cycle pulse in FIN.
- `err`  out  1  sticky timeout flag; cleared on the next accepted start.
- `hv_out`  out  DIM  bundled result; valid from the `done` pulse until the next accepted start.
- `bun_en`  out  1  one-cycle request to the bundler.
- `bun_bits`  out  NUM_HVS  `bun_bits[k]` = hv k bit idx; held stable through ISSUE and WAIT.
- `bun_tie_1`, `bun_tie_2`  out  1 each  LFSR bits [0] and [1] when NUM_HVS is even; 0 when odd.
- `bun_done`  in  1  bundler completion; sampled in WAIT only.
- `bun_out_bit`  in  1  majority result; captured with `bun_done`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE + `start`:
  - latch `hv_in` into the buffer
  - idx←0, `hv_out`←0, `err`←0
  - go to ISSUE
- ISSUE: `bun_en`=1 for exactly this cycle; then go to WAIT.
- WAIT + `bun_done`:
  - `hv_out[idx]`←`bun_out_bit`
  - LFSR steps once
  - if idx==DIM-1, go to FIN; else idx←idx+1 and go to ISSUE.
- FIN: `done`=1, `busy`=0 next cycle; return to IDLE.
- `start` is ignored outside IDLE.
- `bun_done` is ignored outside WAIT.
- idx width is $clog2(DIM) with a minimum of 1; there is no wrap-around past DIM-1.
- LFSR:
  - 16-bit Galois, taps 16'hB400
  - shifts right; when the LSB is 1, XOR the shifted value with the tap mask
  - advances once per completed dimension regardless of NUM_HVS parity.
- Reset, any state, including mid-bundle:
  - state→IDLE, idx→0, LFSR→SEED
  - all outputs 0, including `hv_out` and `err`
  - the buffer contents are don't-care.

## Timing
- The bundler asserts `bun_done` L_b≥1 cycles after the `bun_en` cycle.
- Per-bit period: L_b+1 cycles.
- Accepted start at edge 0:
  - first `bun_en` in cycle 1
  - `done` pulse in cycle DIM·(L_b+1)+1
  - example: DIM=1, L_b=1 gives `done` in cycle 3.
- Back-to-back: `start` in the cycle after FIN is accepted.

## Configuration
- `BUNDLE_TIMEOUT_EN` defined:
  - a counter runs in WAIT.
  - if TIMEOUT cycles pass without `bun_done`, set `err`=1, go to FIN and pulse `done`.
  - `hv_out` holds the bits completed so far; the remaining bits are 0.
- Undefined: no counter, `err` tied 0, WAIT lasts indefinitely.

## Structure
- Package `hdc_bundle_pkg` holds:
  - the state enum
  - LFSR width and tap constants.
- Sub-module `hv_lfsr` provides the LFSR, with ports `clk`, `rst`, `step`, `q[15:0]`.

## Test plan
Benches use NUM_HVS=6, DIM=4 and a behavioural bundler model with L_b=2 unless stated.
- Reset held for 3 cycles, then released → all outputs 0, `busy`=0, no `bun_en`.
- hv0=4'b1111, hv1=4'b1111, hv2=4'b1111, hv3=4'b1111, hv4=4'b0000, hv5=4'b0000:
  - `bun_en` fires 4 times, 3 cycles apart
  - `done` in cycle 13; `hv_out`=4'b1111.
- All 3-3 ties, hv0..2=4'b1010 and hv3..5=4'b0101:
  - each `bun_tie_1`/`bun_tie_2` pair equals the LFSR bits seeded 16'hACE1, with one step per bit
  - `hv_out` matches the reference model's tie resolution.
- NUM_HVS=5 (odd): tie outputs stay 0 for the whole run; `hv_out` is the plain majority.
- `rst` asserted in WAIT at idx=2 → next cycle IDLE, `hv_out`=0, LFSR=SEED; a new `start` then completes normally.
- With `BUNDLE_TIMEOUT_EN` and TIMEOUT=16, the model never asserts `bun_done` at idx=1:
  - `err`=1 and `done` pulses 16 cycles into that WAIT
  - `hv_out` bits 3..1 are 0.

Source files
------------

// File: rtl/hdc_bundle_pkg.sv
// hdc_bundle_pkg
// Shared definitions for the hypervector bundling sequencer:
//   - state_e    : sequencer FSM states
//   - LFSR_W     : tie-break LFSR width
//   - LFSR_TAPS  : Galois tap mask of the tie-break LFSR
//   - lfsr_next(): one right-shifting Galois step
package hdc_bundle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int               LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Shift right; when the bit shifted out was 1, fold the tap mask back in.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/hv_lfsr.sv
// hv_lfsr
// 16-bit Galois LFSR producing tie-break bits for the bundler.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset, loads SEED
//   step in   advance the register by one step this cycle
//   q    out  current LFSR state
module hv_lfsr
  import hdc_bundle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bundler_seq_ctrl.sv
// bundler_seq_ctrl
// Walks a set of NUM_HVS latched hypervectors column by column, handing each
// bit column (plus LFSR tie-break bits when NUM_HVS is even) to the per-bit
// majority bundler and collecting its result into hv_out.
// Optional feature macro: BUNDLE_TIMEOUT_EN -- bounds each WAIT to TIMEOUT
// cycles, raising sticky err and finishing early when the bundler stalls.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   start           begin a bundle (only looked at in IDLE)
//   hv_in           NUM_HVS hypervectors, hv k at [k*DIM +: DIM]
//   busy            high from the cycle after start through FIN
//   done            one-cycle pulse in FIN
//   err             sticky timeout flag (always 0 without the macro)
//   hv_out          bundled result
//   bun_en          one-cycle request to the bundler
//   bun_bits        current bit column, bun_bits[k] = hv k bit idx
//   bun_tie_1/2     LFSR bits [0]/[1] for even NUM_HVS, else 0
//   bun_done        bundler completion (looked at in WAIT only)
//   bun_out_bit     bundler majority result, taken with bun_done
module bundler_seq_ctrl
  import hdc_bundle_pkg::*;
#(
  parameter int               NUM_HVS = 6,
  parameter int               DIM     = 64,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int               TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_HVS*DIM-1:0] hv_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DIM-1:0]         hv_out,
  output logic                   bun_en,
  output logic [NUM_HVS-1:0]     bun_bits,
  output logic                   bun_tie_1,
  output logic                   bun_tie_2,
  input  logic                   bun_done,
  input  logic                   bun_out_bit
);

  localparam int            IDX_W    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIM-1:0]     hv_out_q, hv_out_d;
  logic               load;
  logic               lfsr_step;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               col_active;

  // Buffer stored column-major so one index fetches the whole bit column.
  logic [NUM_HVS-1:0] hv_col [DIM];
  logic [NUM_HVS-1:0] col_mem [DIM];

  genvar gi, gj;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_col
      for (gj = 0; gj < NUM_HVS; gj++) begin : g_hv
        assign hv_col[gi][gj] = hv_in[gj*DIM + gi];
      end
    end
  endgenerate

  // Contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (load) begin
      col_mem <= hv_col;
    end
  end

`ifdef BUNDLE_TIMEOUT_EN
  localparam int            TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // ---------------- next-state / datapath ----------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hv_out_d  = hv_out_q;
    load      = 1'b0;
    lfsr_step = 1'b0;
`ifdef BUNDLE_TIMEOUT_EN
    err_d     = err_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          idx_d    = '0;
          hv_out_d = '0;
`ifdef BUNDLE_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef BUNDLE_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bun_done) begin
          hv_out_d[idx_q] = bun_out_bit;
          lfsr_step       = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
`ifdef BUNDLE_TIMEOUT_EN
        // Counter holds the number of WAIT cycles already spent without
        // bun_done; the TIMEOUT-th such cycle gives up.
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hv_out_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hv_out_q <= hv_out_d;
    end
  end

`ifdef BUNDLE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------- tie-break LFSR ----------------
  hv_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // ---------------- outputs ----------------
  // Column and tie bits are only driven while a transaction is in flight so
  // that every output reads 0 out of reset and between bundles.
  assign col_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign bun_en     = (state_q == ST_ISSUE);
  assign hv_out     = hv_out_q;
  assign bun_bits   = col_active ? col_mem[idx_q] : '0;

  generate
    if ((NUM_HVS % 2) == 0) begin : g_even
      assign bun_tie_1 = col_active & lfsr_q[0];
      assign bun_tie_2 = col_active & lfsr_q[1];
    end else begin : g_odd
      assign bun_tie_1 = 1'b0;
      assign bun_tie_2 = 1'b0;
    end
  endgenerate

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q;

endmodule

// File: tb/tb_bundler_seq_ctrl.sv
module tb_bundler_seq_ctrl;

  localparam int          N6   = 6;
  localparam int          N5   = 5;
  localparam int          D    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // DUT with 6 hypervectors (even -> tie bits used)
  logic            start6 = 1'b0;
  logic [N6*D-1:0] hv6 = '0;
  logic            busy6, done6, err6, en6, tie16, tie26;
  logic [D-1:0]    out6;
  logic [N6-1:0]   bits6;
  logic            bd6 = 1'b0, bo6 = 1'b0;

  // DUT with 5 hypervectors (odd -> no ties)
  logic            start5 = 1'b0;
  logic [N5*D-1:0] hv5 = '0;
  logic            busy5, done5, err5, en5, tie15, tie25;
  logic [D-1:0]    out5;
  logic [N5-1:0]   bits5;
  logic            bd5 = 1'b0, bo5 = 1'b0;

  int tests = 0;
  int fails = 0;

  // bundler model knobs
  int lb6 = 2;
  int lb5 = 2;
  int hang_idx6 = -1;

  // reference LFSR states (advance once per completed dimension)
  logic [15:0] lfsr6_m = SEED;
  logic [15:0] lfsr5_m = SEED;

  bundler_seq_ctrl #(.NUM_HVS(N6), .DIM(D), .SEED(SEED), .TIMEOUT(16)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .hv_in(hv6),
    .busy(busy6), .done(done6), .err(err6), .hv_out(out6),
    .bun_en(en6), .bun_bits(bits6), .bun_tie_1(tie16), .bun_tie_2(tie26),
    .bun_done(bd6), .bun_out_bit(bo6)
  );

  bundler_seq_ctrl #(.NUM_HVS(N5), .DIM(D), .SEED(SEED), .TIMEOUT(16)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .hv_in(hv5),
    .busy(busy5), .done(done5), .err(err5), .hv_out(out5),
    .bun_en(en5), .bun_bits(bits5), .bun_tie_1(tie15), .bun_tie_2(tie25),
    .bun_done(bd5), .bun_out_bit(bo5)
  );

  // ---------------- reference helpers ----------------
  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // majority of n votes; an exact tie is settled by the tie bit
  function automatic logic maj_ref(input logic [7:0] col, input int n, input logic tie);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(col[i]);
    if (2 * c > n) return 1'b1;
    if (2 * c < n) return 1'b0;
    return tie;
  endfunction

  function automatic logic [7:0] col_of(input logic [N6*D-1:0] hv, input int n, input int k);
    logic [7:0] col;
    col = '0;
    for (int h = 0; h < n; h++) col[h] = hv[h*D + k];
    return col;
  endfunction

  // ---------------- behavioural bundlers ----------------
  int   cnt6 = 0, seen6 = 0, cnt5 = 0;
  logic res6 = 1'b0, res5 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      bd6 <= 1'b0; bo6 <= 1'b0; cnt6 <= 0; seen6 <= 0;
    end else begin
      bd6 <= 1'b0;
      if (start6) seen6 <= 0;
      if (en6) begin
        seen6 <= seen6 + 1;
        res6  <= maj_ref({2'b00, bits6}, N6, tie16);
        if (seen6 == hang_idx6) begin
          cnt6 <= 0;
        end else if (lb6 == 1) begin
          bd6 <= 1'b1;
          bo6 <= maj_ref({2'b00, bits6}, N6, tie16);
        end else begin
          cnt6 <= lb6 - 1;
        end
      end else if (cnt6 > 0) begin
        cnt6 <= cnt6 - 1;
        if (cnt6 == 1) begin
          bd6 <= 1'b1;
          bo6 <= res6;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bd5 <= 1'b0; bo5 <= 1'b0; cnt5 <= 0;
    end else begin
      bd5 <= 1'b0;
      if (en5) begin
        res5 <= maj_ref({3'b000, bits5}, N5, 1'b0);
        if (lb5 == 1) begin
          bd5 <= 1'b1;
          bo5 <= maj_ref({3'b000, bits5}, N5, 1'b0);
        end else begin
          cnt5 <= lb5 - 1;
        end
      end else if (cnt5 > 0) begin
        cnt5 <= cnt5 - 1;
        if (cnt5 == 1) begin
          bd5 <= 1'b1;
          bo5 <= res5;
        end
      end
    end
  end

  // ---------------- one full bundle on the even DUT ----------------
  // Entered and left on a falling edge with the DUT idle.
  task automatic run6(input logic [N6*D-1:0] hv, input int lb, input string name);
    logic [D-1:0] exp_out;
    logic [7:0]   col;
    int           k, c;
    bit           got_done;
    lb6 = lb;
    hv6 = hv;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    hv6 = {$urandom, $urandom};   // buffer must have latched on start
    exp_out = '0; k = 0; c = 1; got_done = 0;
    while (c < 200 && !got_done) begin
      if (en6) begin
        col = col_of(hv, N6, k);
        $display("[TB] %s idx=%0d cycle=%0d bits=%b tie=%b%b", name, k, c, bits6, tie26, tie16);
        tests++;
        if (k >= D || bits6 !== col[N6-1:0] || tie16 !== lfsr6_m[0] || tie26 !== lfsr6_m[1]
            || c != 1 + k * (lb + 1)) begin
          fails++;
          $display("FAIL %s issue idx=%0d: got bits=%b ties=%b%b cycle=%0d, want bits=%b ties=%b%b cycle=%0d",
                   name, k, bits6, tie26, tie16, c, col[N6-1:0], lfsr6_m[1], lfsr6_m[0], 1 + k * (lb + 1));
        end
        if (k < D) exp_out[k] = maj_ref(col, N6, lfsr6_m[0]);
        k++;
      end
      if (bd6) lfsr6_m = lfsr_ref(lfsr6_m);
      if (done6) begin
        got_done = 1;
        tests++;
        if (out6 !== exp_out || c != D * (lb + 1) + 1 || k != D || err6 !== 1'b0 || busy6 !== 1'b1) begin
          fails++;
          $display("FAIL %s done: got hv_out=%b cycle=%0d issues=%0d err=%b busy=%b, want hv_out=%b cycle=%0d issues=%0d err=0 busy=1",
                   name, out6, c, k, err6, busy6, exp_out, D * (lb + 1) + 1, D);
        end
      end
      @(negedge clk);
      c++;
    end
    tests++;
    if (!got_done) begin
      fails++;
      $display("FAIL %s no done within cycle budget: got none, want done", name);
    end else if (busy6 !== 1'b0 || done6 !== 1'b0 || out6 !== exp_out) begin
      fails++;
      $display("FAIL %s after FIN: got busy=%b done=%b hv_out=%b, want busy=0 done=0 hv_out=%b",
               name, busy6, done6, out6, exp_out);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lfsr6_m = SEED;
    lfsr5_m = SEED;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({busy6, done6, err6, en6, tie16, tie26, out6, bits6} !== '0 ||
          {busy5, done5, err5, en5, tie15, tie25, out5, bits5} !== '0) begin
        fails++;
        $display("FAIL reset outputs cycle %0d: got dut6=%b dut5=%b, want all zero", i,
                 {busy6, done6, err6, en6, tie16, tie26, out6, bits6},
                 {busy5, done5, err5, en5, tie15, tie25, out5, bits5});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_majority();
    // hv0..3 = 1111, hv4..5 = 0000 -> 4 of 6 ones in every column
    run6({4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111}, 2, "majority");
    tests++;
    if (out6 !== 4'b1111) begin
      fails++;
      $display("FAIL majority literal: got hv_out=%b, want 1111", out6);
    end
  endtask

  task automatic test_ties();
    run6({4'b0101, 4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b1010}, 2, "ties");
  endtask

  task automatic test_odd();
    logic [N5*D-1:0] hv;
    logic [D-1:0]    exp_out;
    logic [7:0]      col;
    int              k, c;
    bit              got_done, tie_seen;
    hv = N5'(0);
    hv = {$urandom, $urandom};
    for (int kk = 0; kk < D; kk++) begin
      col = col_of({4'b0000, hv}, N5, kk);
      exp_out[kk] = maj_ref(col, N5, 1'b0);
    end
    lb5 = 2;
    hv5 = hv;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    k = 0; c = 1; got_done = 0; tie_seen = 0;
    while (c < 200 && !got_done) begin
      if (tie15 !== 1'b0 || tie25 !== 1'b0) tie_seen = 1;
      if (en5) begin
        col = col_of({4'b0000, hv}, N5, k);
        $display("[TB] odd idx=%0d cycle=%0d bits=%b tie=%b%b", k, c, bits5, tie25, tie15);
        tests++;
        if (bits5 !== col[N5-1:0]) begin
          fails++;
          $display("FAIL odd issue idx=%0d: got bits=%b, want %b", k, bits5, col[N5-1:0]);
        end
        k++;
      end
      if (done5) got_done = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    tests++;
    if (!got_done || out5 !== exp_out || tie_seen || c != D * 3 + 1) begin
      fails++;
      $display("FAIL odd done: got done=%0b hv_out=%b ties_seen=%0b cycle=%0d, want done=1 hv_out=%b ties_seen=0 cycle=%0d",
               got_done, out5, tie_seen, c, exp_out, D * 3 + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k, c;
    hv6 = {$urandom, $urandom};
    lb6 = 2;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    k = 0; c = 0;
    while (k < 3 && c < 100) begin
      if (en6) k++;
      @(negedge clk);
      c++;
    end
    // now in the first WAIT cycle of idx 2
    tests++;
    if (k != 3 || busy6 !== 1'b1 || en6 !== 1'b0) begin
      fails++;
      $display("FAIL mid-reset setup: got issues=%0d busy=%b en=%b, want issues=3 busy=1 en=0", k, busy6, en6);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lfsr6_m = SEED;
    lfsr5_m = SEED;
    tests++;
    if ({busy6, done6, err6, en6, tie16, tie26, out6, bits6} !== '0) begin
      fails++;
      $display("FAIL mid-reset state: got %b, want all zero",
               {busy6, done6, err6, en6, tie16, tie26, out6, bits6});
    end
    // LFSR back at SEED shows up on the first tie bits of this run
    run6({$urandom, $urandom}, 2, "after_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run6({$urandom, $urandom}, int'($urandom_range(1, 3)), "b2b");
    end
  endtask

`ifdef BUNDLE_TIMEOUT_EN
  task automatic test_timeout();
    logic [N6*D-1:0] hv;
    logic [7:0]      col;
    logic            bit0;
    int              c;
    bit              got_done;
    hv = {$urandom, $urandom};
    col = col_of(hv, N6, 0);
    bit0 = maj_ref(col, N6, lfsr6_m[0]);
    hang_idx6 = 1;
    lb6 = 2;
    hv6 = hv;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    c = 1; got_done = 0;
    while (c < 200 && !got_done) begin
      if (bd6) lfsr6_m = lfsr_ref(lfsr6_m);
      if (done6) got_done = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    // idx1 ISSUE at cycle 4, WAIT cycles 5..20, FIN at 21
    tests++;
    if (!got_done || err6 !== 1'b1 || c != 21 || out6[3:1] !== 3'b000 || out6[0] !== bit0) begin
      fails++;
      $display("FAIL timeout: got done=%0b err=%b cycle=%0d hv_out=%b, want done=1 err=1 cycle=21 hv_out=000%b",
               got_done, err6, c, out6, bit0);
    end
    @(negedge clk);
    tests++;
    if (err6 !== 1'b1 || busy6 !== 1'b0) begin
      fails++;
      $display("FAIL timeout sticky: got err=%b busy=%b, want err=1 busy=0", err6, busy6);
    end
    hang_idx6 = -1;
    run6({$urandom, $urandom}, 2, "after_tmo");
  endtask
`endif

  initial begin
    test_reset();
    test_majority();
    test_ties();
    test_odd();
    test_reset_mid();
    test_back_to_back();
`ifdef BUNDLE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
